mole_cmd_sink: RTL and testbench

Processor-to-LED command sink for the whack-a-mole game. It snoops the processor's register-file write port and captures writes to a designated command register. Each captured write is queued and later turned into mole-LED on/off state with a per-LED timeout. Button hits and timeouts come back as one-cycle `hit_o`/`miss_o` pulses, which the score-injection logic consumes.

---
 rtl/mole_pkg.sv | 27 ++
 rtl/cmd_fifo.sv | 61 ++++++
 rtl/mole_cmd_sink.sv | 154 +++++++++++++++
 tb/tb_mole_cmd_sink.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole LED command path.
package mole_pkg;

    localparam int unsigned CMD_W            = 32;
    localparam int unsigned LED_IDX_LSB      = 0;
    localparam int unsigned LED_IDX_MSB      = 1;
    localparam int unsigned OP_BIT           = 2;
    localparam int unsigned DUR_LSB          = 8;
    localparam int unsigned DUR_W            = CMD_W - DUR_LSB;
    localparam int unsigned IDX_W            = LED_IDX_MSB - LED_IDX_LSB + 1;
    localparam int unsigned RSVD_W           = DUR_LSB - OP_BIT - 1;
    localparam int unsigned DEFAULT_NUM_LEDS = 4;
    localparam logic [4:0]  DEFAULT_CMD_REG  = 5'd29;

    // Command mailbox word as written by the processor.
    typedef struct packed {
        logic [DUR_W-1:0]  dur;
        logic [RSVD_W-1:0] rsvd;
        logic              op;
        logic [IDX_W-1:0]  idx;
    } cmd_t;

    function automatic cmd_t to_cmd(input logic [CMD_W-1:0] word);
        return cmd_t'(word);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous show-ahead FIFO; DEPTH must be a power of two, at least 2.
module cmd_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata_c,
    output logic                     full_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic             do_push;
    logic             do_pop;

    assign full_c  = (level == LW'(DEPTH));
    assign empty_c = (level == '0);
    assign do_pop  = pop & ~empty_c;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_push = push & (~full_c | do_pop);
    assign rdata_c = mem_q[rptr_q];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/mole_cmd_sink.sv
// Captures regfile writes to the LED mailbox and drives mole LEDs with timeouts.
module mole_cmd_sink
    import mole_pkg::*;
#(
    parameter logic [4:0]  CMD_REG  = DEFAULT_CMD_REG,
    parameter int unsigned NUM_LEDS = DEFAULT_NUM_LEDS,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TICK_DIV = 25000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rwe,
    input  logic [4:0]             rd,
    input  logic [31:0]            rdata,
    input  logic [NUM_LEDS-1:0]    btn_n,
    output logic [NUM_LEDS-1:0]    led_o,
    output logic [NUM_LEDS-1:0]    hit_o,
    output logic [NUM_LEDS-1:0]    miss_o,
    output logic                   overflow_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TICK_W-1:0] presc_q;
    logic              tick;
    logic              push_req;
    logic              pop;
    logic [31:0]       fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    cmd_t              cmd;
    logic              cmd_valid;
    logic [RSVD_W-1:0] unused_rsvd;

    assign tick      = (presc_q == TICK_W'(TICK_DIV - 1));
    // r0 is hard-wired zero on the processor, so writes to it never count.
    assign push_req  = rwe && (rd == CMD_REG) && (rd != 5'd0);
    assign pop       = tick & ~fifo_empty;
    assign cmd       = to_cmd(fifo_rdata);
    assign cmd_valid = pop && (32'(cmd.idx) < NUM_LEDS);
    assign unused_rsvd = cmd.rsvd;

    // Free-running tick prescaler.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + TICK_W'(1);
        end
    end

    // Sticky drop flag: push against a full FIFO with no pop to make room.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_o <= 1'b0;
        end else if (push_req && fifo_full && !pop) begin
            overflow_o <= 1'b1;
        end
    end

    cmd_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push    (push_req),
        .wdata   (rdata),
        .pop     (pop),
        .rdata_c (fifo_rdata),
        .full_c  (fifo_full),
        .empty_c (fifo_empty),
        .level   (level_o)
    );

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
        logic [1:0]       sync_q;
        logic             prev_q;
        logic             fall;
        logic             sel;
        logic             hit;
        logic             expire;
        logic             lit_q;
        logic             hit_q;
        logic             miss_q;
        logic [DUR_W-1:0] timer_q;
        logic             lit_d;
        logic             hit_d;
        logic             miss_d;
        logic [DUR_W-1:0] timer_d;

        assign fall   = prev_q & ~sync_q[1];
        assign sel    = cmd_valid && (32'(cmd.idx) == i);
        assign hit    = fall & lit_q;
        assign expire = tick & lit_q & (timer_q == DUR_W'(1));

        // Button synchronizer plus previous-value flop for falling-edge detect.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_q <= 2'b11;
                prev_q <= 1'b1;
            end else begin
                sync_q <= {sync_q[0], btn_n[i]};
                prev_q <= sync_q[1];
            end
        end

        // Next LED state: command wins the state, hit beats expiry.
        always_comb begin
            lit_d   = lit_q;
            timer_d = timer_q;
            hit_d   = 1'b0;
            miss_d  = 1'b0;
            if (sel) begin
                lit_d   = cmd.op;
                timer_d = cmd.op ? cmd.dur : '0;
                hit_d   = hit;
            end else if (hit) begin
                lit_d   = 1'b0;
                timer_d = '0;
                hit_d   = 1'b1;
            end else if (expire) begin
                lit_d   = 1'b0;
                timer_d = '0;
                miss_d  = 1'b1;
            end else if (tick && lit_q && (timer_q != '0)) begin
                timer_d = timer_q - DUR_W'(1);
            end
        end

        // LED, timer and pulse registers.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                lit_q   <= 1'b0;
                timer_q <= '0;
                hit_q   <= 1'b0;
                miss_q  <= 1'b0;
            end else begin
                lit_q   <= lit_d;
                timer_q <= timer_d;
                hit_q   <= hit_d;
                miss_q  <= miss_d;
            end
        end

        assign led_o[i]  = lit_q;
        assign hit_o[i]  = hit_q;
        assign miss_o[i] = miss_q;
    end

endmodule

// File: tb/tb_mole_cmd_sink.sv
// Directed and random checks of mole_cmd_sink against a behavioural model.
module tb_mole_cmd_sink;

    localparam int unsigned TD    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NL    = 4;
    localparam logic [4:0]  CREG  = 5'd29;

    logic        clk;
    logic        reset;
    logic        rwe;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [3:0]  btn_n;
    logic [3:0]  led_o;
    logic [3:0]  hit_o;
    logic [3:0]  miss_o;
    logic        overflow_o;
    logic [2:0]  level_o;

    int compared;
    int mismatched;
    int n_hit[NL];
    int n_miss[NL];

    // Reference model state
    int unsigned m_pres;
    bit [31:0]   m_q[$];
    bit          m_lit[NL];
    int unsigned m_rem[NL];
    bit [3:0]    m_hit;
    bit [3:0]    m_miss;
    bit          m_ovf;
    bit [3:0]    m_hist[$];

    mole_cmd_sink #(
        .CMD_REG  (CREG),
        .NUM_LEDS (NL),
        .DEPTH    (DEPTH),
        .TICK_DIV (TD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rwe        (rwe),
        .rd         (rd),
        .rdata      (rdata),
        .btn_n      (btn_n),
        .led_o      (led_o),
        .hit_o      (hit_o),
        .miss_o     (miss_o),
        .overflow_o (overflow_o),
        .level_o    (level_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pres = 0;
        m_q.delete();
        m_hit  = '0;
        m_miss = '0;
        m_ovf  = 1'b0;
        for (int i = 0; i < NL; i++) begin
            m_lit[i] = 1'b0;
            m_rem[i] = 0;
        end
        m_hist = '{4'hF, 4'hF, 4'hF};
    endtask

    // One clock edge of the game rules, using inputs as seen at the edge.
    task automatic model_edge();
        bit        tk;
        bit [3:0]  fall;
        bit        have;
        bit [31:0] c;
        bit        hit;
        bit        expd;
        tk     = (m_pres == TD - 1);
        m_pres = tk ? 0 : m_pres + 1;
        fall   = m_hist[2] & ~m_hist[1];
        have   = 1'b0;
        c      = '0;
        if (tk && m_q.size() > 0) begin
            c    = m_q.pop_front();
            have = 1'b1;
        end
        if (rwe && rd == CREG && rd != 5'd0) begin
            if (m_q.size() < DEPTH) m_q.push_back(rdata);
            else m_ovf = 1'b1;
        end
        m_hist.push_front(btn_n);
        void'(m_hist.pop_back());
        for (int i = 0; i < NL; i++) begin
            hit       = fall[i] && m_lit[i];
            expd      = tk && m_lit[i] && m_rem[i] == 1;
            m_hit[i]  = 1'b0;
            m_miss[i] = 1'b0;
            if (have && int'(c[1:0]) == i) begin
                m_lit[i] = c[2];
                m_rem[i] = c[2] ? int'(c[31:8]) : 0;
                m_hit[i] = hit;
            end else if (hit) begin
                m_lit[i] = 1'b0;
                m_rem[i] = 0;
                m_hit[i] = 1'b1;
            end else if (expd) begin
                m_lit[i]  = 1'b0;
                m_rem[i]  = 0;
                m_miss[i] = 1'b1;
            end else if (tk && m_lit[i] && m_rem[i] > 0) begin
                m_rem[i] = m_rem[i] - 1;
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] el;
        for (int i = 0; i < NL; i++) begin
            el[i] = m_lit[i];
            n_hit[i]  += int'(hit_o[i]);
            n_miss[i] += int'(miss_o[i]);
        end
        chk("led_o", 32'(led_o), 32'(el));
        chk("hit_o", 32'(hit_o), 32'(m_hit));
        chk("miss_o", 32'(miss_o), 32'(m_miss));
        chk("overflow_o", 32'(overflow_o), 32'(m_ovf));
        chk("level_o", 32'(level_o), 32'(m_q.size()));
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NL; i++) begin
            n_hit[i]  = 0;
            n_miss[i] = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic write(input logic [4:0] r, input logic [31:0] d);
        rwe   = 1'b1;
        rd    = r;
        rdata = d;
        step();
        rwe   = 1'b0;
        rd    = '0;
        rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Step until the cycle right after a tick edge.
    task automatic align_tick();
        for (int k = 0; k < int'(TD) && m_pres != 0; k++) step();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rwe   = 1'b0;
        rd    = '0;
        rdata = '0;
        btn_n = 4'hF;
        reset = 1'b0;
        clear_counts();
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        chk("reset_led", 32'(led_o), 32'h0);
        chk("reset_level", 32'(level_o), 32'h0);

        // Timeout: LED1, duration 10
        write(5'd29, 32'h0000_0A05);
        chk("capture_level", 32'(level_o), 32'd1);
        clear_counts();
        run(12 * TD);
        chk("to_miss1", 32'(n_miss[1]), 32'd1);
        chk("to_hit1", 32'(n_hit[1]), 32'd0);
        chk("to_led1", 32'(led_o[1]), 32'd0);

        // Hit path
        do_reset();
        write(5'd29, 32'h0000_0A05);
        run(TD);
        chk("hit_lit1", 32'(led_o[1]), 32'd1);
        run(3 * TD);
        clear_counts();
        btn_n[1] = 1'b0;
        run(4);
        chk("hit_hit1", 32'(n_hit[1]), 32'd1);
        chk("hit_led1", 32'(led_o[1]), 32'd0);
        btn_n[1] = 1'b1;
        clear_counts();
        run(20 * TD);
        chk("hit_nomiss1", 32'(n_miss[1]), 32'd0);

        // Filtering: wrong register, then force-off of unlit LED
        do_reset();
        clear_counts();
        write(5'd28, 32'h0000_0A05);
        write(5'd29, 32'h0000_0A00);
        run(3 * TD);
        chk("filt_led", 32'(led_o), 32'h0);
        chk("filt_level", 32'(level_o), 32'h0);
        chk("filt_hits", 32'(n_hit[0] + n_hit[1] + n_hit[2] + n_hit[3]), 32'd0);
        chk("filt_miss", 32'(n_miss[0] + n_miss[1] + n_miss[2] + n_miss[3]), 32'd0);

        // Overflow: five back-to-back writes between ticks
        do_reset();
        align_tick();
        write(5'd29, 32'h0000_0004);
        write(5'd29, 32'h0000_0005);
        write(5'd29, 32'h0000_0006);
        write(5'd29, 32'h0000_0007);
        write(5'd29, 32'h0000_0000);
        chk("ovf_level", 32'(level_o), 32'd4);
        chk("ovf_flag", 32'(overflow_o), 32'd1);
        run(4 * TD);
        chk("ovf_leds", 32'(led_o), 32'hF);
        chk("ovf_drained", 32'(level_o), 32'd0);
        chk("ovf_sticky", 32'(overflow_o), 32'd1);

        // Collision: LED0 duration 1, hit lands on expiry edge
        do_reset();
        write(5'd29, 32'h0000_0104);
        for (int k = 0; k < int'(2 * TD) && !m_lit[0]; k++) step();
        chk("col_lit0", 32'(led_o[0]), 32'd1);
        for (int k = 0; k < int'(TD) && m_pres != TD - 3; k++) step();
        clear_counts();
        btn_n[0] = 1'b0;
        run(4);
        btn_n[0] = 1'b1;
        run(4);
        chk("col_hit0", 32'(n_hit[0]), 32'd1);
        chk("col_miss0", 32'(n_miss[0]), 32'd0);
        chk("col_led0", 32'(led_o[0]), 32'd0);

        // Reset mid-operation
        do_reset();
        write(5'd29, 32'h0000_0006);
        run(TD + 1);
        chk("rst_lit2", 32'(led_o[2]), 32'd1);
        align_tick();
        write(5'd29, 32'h0000_0205);
        write(5'd29, 32'h0000_0004);
        chk("rst_level2", 32'(level_o), 32'd2);
        clear_counts();
        do_reset();
        chk("rst_led", 32'(led_o), 32'h0);
        chk("rst_level", 32'(level_o), 32'h0);
        run(3 * TD);
        chk("rst_after_led", 32'(led_o), 32'h0);
        chk("rst_pulses", 32'(n_hit[0] + n_hit[1] + n_miss[0] + n_miss[1] + n_hit[2] + n_miss[2]), 32'd0);

        // Random traffic against the model
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                rwe = 1'b1;
                case ($urandom_range(0, 4))
                    0, 1, 2: rd = 5'd29;
                    3:       rd = 5'd0;
                    default: rd = 5'($urandom);
                endcase
                rdata = {24'($urandom_range(0, 6)), 5'($urandom), 1'($urandom), 2'($urandom)};
            end else begin
                rwe   = 1'b0;
                rd    = '0;
                rdata = '0;
            end
            if ($urandom_range(0, 9) == 0) begin
                btn_n[$urandom_range(0, 3)] ^= 1'b1;
            end
            step();
        end
        rwe   = 1'b0;
        btn_n = 4'hF;
        run(4 * TD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
